// File: rtl/rv32i_lsu_if.sv
// rv32i_lsu_if: request/response handshake between the core and the
// load/store unit, plus the synchronous data-memory port.
//   req_*   core -> LSU request (valid/ready handshake)
//   resp_*  LSU -> core completion pulse, read data, error flag
//   data_*  LSU <-> data memory (word address, byte enables, write/read data)
// modport slave  : the LSU side
// modport master : the core + memory side (testbench)
interface rv32i_lsu_if #(
  parameter int DMEM_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic [DMEM_WIDTH-1:0] data_addr;
  logic [3:0]            data_we;
  logic [31:0]           data_write;
  logic [31:0]           data_read;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, data_read,
    output req_ready, resp_valid, resp_rdata, resp_error,
           data_addr, data_we, data_write
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, data_read,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           data_addr, data_we, data_write
  );
endinterface

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit between the rv32i execute logic and a data
// memory with a one-cycle synchronous read.  One request in flight at a time.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    rv32i_lsu_if.slave: req_* request, resp_* completion,
//          data_* memory word address / byte enables / write & read data
// Stores complete in 3 cycles, loads in 4 (including the IDLE cycle).
module rv32i_lsu #(
  parameter int DMEM_WIDTH = 16
) (
  input logic        clk,
  input logic        reset,
  rv32i_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [DMEM_WIDTH+1:0] addr_p0;
  logic [2:0]            funct3_p0;
  logic                  store_p0;
  logic [31:0]           wdata_p0;
  logic [31:0]           rdata_p1;
  logic                  error_p1;
  logic                  err_p0;

  function automatic logic access_error(input logic store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic e;
    e = 1'b1;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = |off;
      3'b100:  e = store;
      3'b101:  e = store | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] we;
    case (size)
      2'b00:   we = 4'b0001 << off;
      2'b01:   we = off[1] ? 4'b1100 : 4'b0011;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = signed'(word[{off, 3'b000} +: 8]);
    h = signed'(word[{off[1], 4'b0000} +: 16]);
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decoded only from registered request state, never from req_* inputs.
  assign err_p0 = access_error(store_p0, funct3_p0, addr_p0[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = (err_p0 || store_p0) ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: request capture on acceptance ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p0   <= '0;
      funct3_p0 <= 3'b000;
      store_p0  <= 1'b0;
      wdata_p0  <= 32'h0;
    end else if (state == IDLE && bus.req_valid) begin
      addr_p0   <= bus.req_addr[DMEM_WIDTH+1:0];
      funct3_p0 <= bus.req_funct3;
      store_p0  <= bus.req_store;
      wdata_p0  <= bus.req_wdata;
    end
  end

  // ---- stage p1: response registers, updated only when entering RESP ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p1 <= 32'h0;
      error_p1 <= 1'b0;
    end else if (state == ACCESS && (err_p0 || store_p0)) begin
      rdata_p1 <= 32'h0;
      error_p1 <= err_p0;
    end else if (state == WAIT) begin
      rdata_p1 <= load_extract(funct3_p0, addr_p0[1:0], bus.data_read);
      error_p1 <= 1'b0;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_p1;
  assign bus.resp_error = error_p1;
  assign bus.data_addr  = addr_p0[DMEM_WIDTH+1:2];
  assign bus.data_write = store_data(funct3_p0[1:0], wdata_p0);
  // State resets asynchronously, so the enables collapse as soon as reset rises.
  assign bus.data_we    = (state == ACCESS && store_p0 && !err_p0)
                          ? store_lanes(funct3_p0[1:0], addr_p0[1:0]) : 4'b0000;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: randomized bench for rv32i_lsu with a byte-level reference
// memory and a behavioural model of the RV32I load/store rules.
module tb_rv32i_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_lsu_if #(.DMEM_WIDTH(16)) bus ();

  rv32i_lsu #(.DMEM_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Data memory device: 2^16 words, one-cycle synchronous read.
  bit [31:0] dmem [0:65535];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (bus.data_we[n]) dmem[bus.data_addr][8*n +: 8] <= bus.data_write[8*n +: 8];
    bus.data_read <= dmem[bus.data_addr];
  end

  // Reference: flat byte memory covering the 2^18-byte wrapped address space.
  bit [7:0] ref_mem [0:262143];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_error(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    if (sz == 0) return 1'b1;
    if (st && f3 > 3'd3) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int ba, sz;
    ba = int'(a[17:0]);
    sz = acc_size(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[ba+i]) << (8*i));
    if (f3 == 3'd0 && v >= 128)   v = v - 256;
    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int ba;
    ba = int'(a[17:0]);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[ba+i] = 8'(wd >> (8*i));
  endtask

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // One complete transaction; checks against the reference model.
  task automatic xact(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    bit          exp_err, seen, stray;
    int          off, lat;
    logic [31:0] exp_rd, lane_mask;
    logic [3:0]  exp_we;
    exp_err = ref_error(st, f3, a);
    off     = int'(a[1:0]);
    exp_rd  = (st || exp_err) ? 32'h0 : ref_load(f3, a);
    exp_we  = 4'b0000;
    if (st && !exp_err) begin
      for (int i = 0; i < acc_size(f3); i++) exp_we[off+i] = 1'b1;
      ref_store(f3, a, wd);
    end
    lane_mask = {{8{exp_we[3]}}, {8{exp_we[2]}}, {8{exp_we[1]}}, {8{exp_we[0]}}};
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    chk("access_we", bus.data_we, exp_we);
    chk("access_addr", bus.data_addr, a[17:2]);
    chk("req_ready_busy", bus.req_ready, 0);
    if (exp_we != 4'b0000)
      chk("access_wdata", bus.data_write & lane_mask, (wd << (8*off)) & lane_mask);
    seen = 1'b0; stray = 1'b0; lat = 0; rd = bus.resp_rdata; er = bus.resp_error;
    for (int c = 2; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (bus.data_we != 4'b0000) stray = 1'b1;
      if (bus.resp_valid) begin
        seen = 1'b1; lat = c; rd = bus.resp_rdata; er = bus.resp_error;
      end
    end
    chk("resp_latency", lat, (st || exp_err) ? 2 : 3);
    chk("resp_error", er, exp_err);
    chk("resp_rdata", rd, exp_rd);
    chk("stray_we", stray, 0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc_cnt, resp_cnt, exp_acc, t;
  bit          st;
  logic [2:0]  f3;
  logic [31:0] a;

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_1234; bus.req_wdata = 32'hFFFF_FFFF;
    // Requests during reset must be ignored.
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_error", bus.resp_error, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_data_we", bus.data_we, 0);
    chk("rst_data_addr", bus.data_addr, 0);
    chk("rst_data_write", bus.data_write, 0);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1);

    // Backdoor preload for the extraction cases.
    dmem[0] = 32'h80FF7F01;
    ref_mem[0] = 8'h01; ref_mem[1] = 8'h7F; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;

    xact(1'b0, 3'b000, 32'h2, 32'h0, rd, er); chk("lb_const",  rd, 32'hFFFFFFFF);
    @(negedge clk); @(negedge clk);
    chk("rdata_hold", bus.resp_rdata, 32'hFFFFFFFF);
    xact(1'b0, 3'b100, 32'h2, 32'h0, rd, er); chk("lbu_const", rd, 32'h000000FF);
    xact(1'b0, 3'b001, 32'h2, 32'h0, rd, er); chk("lh_const",  rd, 32'hFFFF80FF);
    xact(1'b0, 3'b101, 32'h2, 32'h0, rd, er); chk("lhu_const", rd, 32'h000080FF);

    // SB at 0x103: lane 3, replicated byte.
    fork
      xact(1'b1, 3'b000, 32'h103, 32'h12345678, rd, er);
      begin
        @(posedge clk); @(negedge clk); @(negedge clk);
        chk("sb_addr", bus.data_addr, 16'h0040);
        chk("sb_we", bus.data_we, 4'b1000);
        chk("sb_write", bus.data_write, 32'h78787878);
      end
    join
    xact(1'b0, 3'b100, 32'h103, 32'h0, rd, er); chk("sb_readback", rd, 32'h00000078);

    // Error cases.
    xact(1'b0, 3'b010, 32'h6, 32'h0, rd, er);        chk("lw_mis_err", er, 1);
    xact(1'b1, 3'b001, 32'h1, 32'hAAAA5555, rd, er); chk("sh_mis_err", er, 1);
    xact(1'b0, 3'b011, 32'h0, 32'h0, rd, er);        chk("f3_011_err", er, 1);

    // Reset during WAIT of an LW: no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h20;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wait_rst_ready", bus.req_ready, 1);
    chk("wait_rst_resp_valid", bus.resp_valid, 0);
    chk("wait_rst_data_addr", bus.data_addr, 0);
    chk("wait_rst_rdata", bus.resp_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    resp_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) resp_cnt++;
    end
    chk("aborted_no_resp", resp_cnt, 0);
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw_after_rst_err", er, 0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("sw_after_rst_readback", rd, 32'hDEADBEEF);

    // Store aborted in ACCESS must not be written.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    chk("abort_access_we", bus.data_we, 4'b1111);
    reset = 1'b1;
    #1 chk("abort_we_drop", bus.data_we, 0);
    @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("abort_not_written", rd, 32'hDEADBEEF);

    // req_valid held for 10 cycles, alternating store/load.
    exp_acc = 0; t = 0;
    while (t < 10) begin
      exp_acc++;
      t += (t % 2 == 0) ? 3 : 4;
    end
    acc_cnt = 0; resp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_cnt++;
      bus.req_valid = 1'b1; bus.req_store = (i % 2 == 0); bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h200 + 32'(4*i); bus.req_wdata = $urandom;
      if (bus.req_ready) begin
        acc_cnt++;
        if (bus.req_store) ref_store(3'b010, bus.req_addr, bus.req_wdata);
      end
    end
    @(negedge clk);
    drive_idle();
    if (bus.resp_valid) resp_cnt++;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) resp_cnt++;
    end
    chk("hold_accepts", acc_cnt, exp_acc);
    chk("hold_resps", resp_cnt, acc_cnt);

    // Randomized mix with wrapping upper address bits.
    for (int k = 0; k < 150; k++) begin
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
      xact(st, f3, a, $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1);
  end

endmodule
